// File: rtl/axi_sram_slave_pkg.sv
// Shared types and constants for the AXI3 SRAM slave: response/burst codes,
// FSM encodings, the latched address-channel request and the beat address step.
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_req_t;

  // WRAP and the reserved encoding are answered with SLVERR rather than served.
  function automatic logic bad_burst(input logic [1:0] burst);
    return (burst != BURST_FIXED) && (burst != BURST_INCR);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
  endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// 1R1W synchronous word RAM with byte write enables; a read in the same cycle
// as a write to the same word returns the old contents.
module axi_slave_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave over an internal SRAM: independent read and write FSMs, one
// outstanding transaction each, INCR/FIXED bursts, programmable read latency.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter logic [31:0] BASE       = 32'h1c000000,
  parameter int          READ_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [3:0] RD_CNT = 4'(READ_DELAY);

  function automatic logic in_range(input logic [31:0] a);
    return a[31:ADDR_W+2] == BASE[31:ADDR_W+2];
  endfunction

  r_state_t    r_state;
  w_state_t    w_state;
  ax_req_t     r_req, w_req;
  logic [7:0]  r_beat, w_cnt;
  logic [3:0]  r_cnt;
  logic        w_err;
  logic [31:0] r_next, rd_addr, w_next, ram_q;
  logic        rd_err, w_beat_err, ram_re, ram_we;

  // The RAM is read either when the wait counter expires or on a beat accept,
  // in which case the next beat's address is fetched so rvalid never drops mid-burst.
  assign r_next     = next_addr(r_req.addr, r_req.size, r_req.burst);
  assign rd_addr    = (r_state == R_DATA) ? r_next : r_req.addr;
  assign rd_err     = bad_burst(r_req.burst) || !in_range(rd_addr);
  assign ram_re     = ((r_state == R_WAIT) && (r_cnt == RD_CNT)) ||
                      ((r_state == R_DATA) && rready && (r_beat != r_req.len));
  assign rdata      = (rvalid && (rresp == RESP_OKAY)) ? ram_q : 32'd0;

  assign w_next     = next_addr(w_req.addr, w_req.size, w_req.burst);
  assign w_beat_err = bad_burst(w_req.burst) || !in_range(w_req.addr);
  assign ram_we     = (w_state == W_DATA) && wvalid && wready && !w_beat_err;

  axi_slave_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .raddr (rd_addr[ADDR_W+1:2]),
    .rdata (ram_q),
    .we    (ram_we),
    .waddr (w_req.addr[ADDR_W+1:2]),
    .wstrb (wstrb),
    .wdata (wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= 4'd0;
      r_req   <= '0;
      r_beat  <= 8'd0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            r_req   <= '{arid, araddr, arlen, arsize, arburst};
            r_beat  <= 8'd0;
            r_cnt   <= 4'd0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == RD_CNT) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rid     <= r_req.id;
            rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (r_req.len == 8'd0);
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_beat == r_req.len) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rresp   <= RESP_OKAY;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_req.addr <= r_next;
              r_beat     <= r_beat + 8'd1;
              rresp      <= rd_err ? RESP_SLVERR : RESP_OKAY;
              rlast      <= (r_beat + 8'd1 == r_req.len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= 4'd0;
      w_req   <= '0;
      w_cnt   <= 8'd0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            w_req   <= '{awid, awaddr, awlen, awsize, awburst};
            w_cnt   <= 8'd0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            w_req.addr <= w_next;
            w_cnt      <= w_cnt + 8'd1;
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_req.id;
              bresp   <= (w_err || w_beat_err || (w_cnt != w_req.len)) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              // A beat beyond awlen without wlast is already a count mismatch.
              w_err <= w_err || w_beat_err || (w_cnt == w_req.len);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  logic unused;
  assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                    rd_addr[1:0], w_req.addr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: write/read, strobes, bursts with stalls,
// error responses, concurrent AR/AW and reset in the middle of a burst.
module tb_axi_sram_slave;

  logic        clk = 1'b0, reset = 1'b1;
  logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
  logic [1:0]  arburst = 2'b01, awburst = 2'b01, arlock = '0, awlock = '0, rresp, bresp;
  logic [3:0]  arcache = '0, awcache = '0, wstrb = '0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;

  int vecs = 0, errs = 0;
  logic [31:0] wr_data [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];

  axi_sram_slave dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int nbeats,
                          output logic [1:0] resp_o, output logic [3:0] id_o, output bit tmo);
    int t;
    tmo = 0; awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1;
    t = 0; while (!awready && t < 50) begin tick(); t++; end
    if (t >= 50) tmo = 1;
    tick(); awvalid = 0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wr_data[i]; wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1;
      t = 0; while (!wready && t < 50) begin tick(); t++; end
      if (t >= 50) tmo = 1;
      tick();
    end
    wvalid = 0; wlast = 0;
    t = 0; while (!bvalid && t < 50) begin tick(); t++; end
    if (t >= 50) tmo = 1;
    resp_o = bresp; id_o = bid; bready = 1;
    tick(); bready = 0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle, output int n, output int lat,
                         output int stall_bad, output bit tmo);
    int t; bit phase, stalled;
    logic [31:0] sd; logic [1:0] sr; logic sl; logic [3:0] si;
    tmo = 0; arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1;
    t = 0; while (!arready && t < 50) begin tick(); t++; end
    if (t >= 50) tmo = 1;
    tick(); arvalid = 0;
    lat = 0; while (!rvalid && lat < 50) begin tick(); lat++; end
    if (lat >= 50) tmo = 1;
    n = 0; phase = 1; stalled = 0; stall_bad = 0; t = 0;
    sd = '0; sr = '0; sl = 0; si = '0;
    while (n <= int'(len) && t < 200) begin
      if (rvalid) begin
        if (stalled && (rdata !== sd || rresp !== sr || rlast !== sl || rid !== si)) stall_bad++;
        rready = toggle ? phase : 1'b1;
        if (rready) begin
          if (n < 16) begin rd_data[n] = rdata; rd_resp[n] = rresp; rd_last[n] = rlast; rd_id[n] = rid; end
          n++; stalled = 0;
        end else begin
          stalled = 1; sd = rdata; sr = rresp; sl = rlast; si = rid;
        end
        phase = ~phase;
      end else begin
        rready = 0; stalled = 0;
      end
      tick(); t++;
    end
    if (t >= 200) tmo = 1;
    rready = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    vecs++; if ({arready, awready, wready} !== 3'b000) begin errs++; $display("FAIL rst_ready got %b exp 000", {arready, awready, wready}); end
    vecs++; if ({rvalid, bvalid, rlast} !== 3'b000) begin errs++; $display("FAIL rst_valid got %b exp 000", {rvalid, bvalid, rlast}); end
    vecs++; if ({rid, bid, rresp, bresp} !== 12'h0) begin errs++; $display("FAIL rst_ids got %h exp 0", {rid, bid, rresp, bresp}); end
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    reset = 0; tick();
    vecs++; if ({arready, awready, wready} !== 3'b110) begin errs++; $display("FAIL rst_release got %b exp 110", {arready, awready, wready}); end
  endtask

  task automatic test_write_read();
    logic [1:0] br; logic [3:0] bi; bit tmo; int n, lat, sb;
    wr_data[0] = 32'hdeadbeef;
    do_write(4'h3, 32'h1c000010, 8'd0, 2'b01, 4'hf, 1, br, bi, tmo);
    vecs++; if (tmo || br !== 2'b00 || bi !== 4'h3) begin errs++; $display("FAIL wr_resp got bresp %h bid %h tmo %0d exp 0/3/0", br, bi, tmo); end
    do_read(4'h1, 32'h1c000010, 8'd0, 2'b01, 0, n, lat, sb, tmo);
    vecs++; if (tmo || n != 1) begin errs++; $display("FAIL rd_count got %0d tmo %0d exp 1", n, tmo); end
    vecs++; if (rd_data[0] !== 32'hdeadbeef) begin errs++; $display("FAIL rd_data got %h exp deadbeef", rd_data[0]); end
    vecs++; if (rd_last[0] !== 1'b1 || rd_id[0] !== 4'h1 || rd_resp[0] !== 2'b00) begin errs++; $display("FAIL rd_ctl got last %b id %h resp %h exp 1/1/0", rd_last[0], rd_id[0], rd_resp[0]); end
    vecs++; if (lat != 2) begin errs++; $display("FAIL rd_latency got %0d exp 2", lat); end
  endtask

  task automatic test_byte_strobe();
    logic [1:0] br; logic [3:0] bi; bit tmo; int n, lat, sb;
    wr_data[0] = 32'h11223344;
    do_write(4'h2, 32'h1c000020, 8'd0, 2'b01, 4'hf, 1, br, bi, tmo);
    wr_data[0] = 32'haabbccdd;
    do_write(4'h2, 32'h1c000020, 8'd0, 2'b01, 4'b0101, 1, br, bi, tmo);
    vecs++; if (tmo || br !== 2'b00) begin errs++; $display("FAIL strb_bresp got %h exp 0", br); end
    do_read(4'h2, 32'h1c000020, 8'd0, 2'b01, 0, n, lat, sb, tmo);
    vecs++; if (tmo || rd_data[0] !== 32'h11bb33dd) begin errs++; $display("FAIL strb_data got %h exp 11bb33dd", rd_data[0]); end
  endtask

  task automatic test_incr_burst();
    logic [1:0] br; logic [3:0] bi; bit tmo; int n, lat, sb;
    for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
    do_write(4'h4, 32'h1c000100, 8'd3, 2'b01, 4'hf, 4, br, bi, tmo);
    vecs++; if (tmo || br !== 2'b00 || bi !== 4'h4) begin errs++; $display("FAIL burst_bresp got %h bid %h exp 0/4", br, bi); end
    do_read(4'h9, 32'h1c000100, 8'd3, 2'b01, 1, n, lat, sb, tmo);
    vecs++; if (tmo || n != 4) begin errs++; $display("FAIL burst_count got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00 || rd_id[i] !== 4'h9)
        begin errs++; $display("FAIL burst_beat%0d got %h last %b resp %h exp %0d", i, rd_data[i], rd_last[i], rd_resp[i], i + 1); end
    end
    vecs++; if (sb != 0) begin errs++; $display("FAIL burst_stall_stable got %0d changes exp 0", sb); end
    do_read(4'h8, 32'h1c000010, 8'd1, 2'b00, 0, n, lat, sb, tmo);
    vecs++; if (tmo || n != 2 || rd_data[0] !== 32'hdeadbeef || rd_data[1] !== 32'hdeadbeef || rd_last[1] !== 1'b1)
      begin errs++; $display("FAIL fixed_burst got %h %h n %0d exp deadbeef x2", rd_data[0], rd_data[1], n); end
  endtask

  task automatic test_errors();
    logic [1:0] br; logic [3:0] bi; bit tmo; int n, lat, sb;
    do_read(4'h6, 32'h00000000, 8'd0, 2'b01, 0, n, lat, sb, tmo);
    vecs++; if (tmo || rd_resp[0] !== 2'b10 || rd_data[0] !== 32'h0) begin errs++; $display("FAIL oor_read got resp %h data %h exp 2/0", rd_resp[0], rd_data[0]); end
    wr_data[0] = 32'hcafef00d;
    do_write(4'h1, 32'h1c000304, 8'd0, 2'b01, 4'hf, 1, br, bi, tmo);
    wr_data[0] = 32'h12345678; wr_data[1] = 32'h87654321;
    do_write(4'h7, 32'h1c000300, 8'd1, 2'b01, 4'hf, 1, br, bi, tmo);
    vecs++; if (tmo || br !== 2'b10 || bi !== 4'h7) begin errs++; $display("FAIL short_wr_bresp got %h bid %h exp 2/7", br, bi); end
    do_read(4'h1, 32'h1c000304, 8'd0, 2'b01, 0, n, lat, sb, tmo);
    vecs++; if (tmo || rd_data[0] !== 32'hcafef00d) begin errs++; $display("FAIL short_wr_mem got %h exp cafef00d", rd_data[0]); end
    wr_data[0] = 32'h0badf00d;
    do_write(4'h5, 32'h20000000, 8'd0, 2'b01, 4'hf, 1, br, bi, tmo);
    vecs++; if (tmo || br !== 2'b10) begin errs++; $display("FAIL oor_wr_bresp got %h exp 2", br); end
    do_read(4'h3, 32'h1c000010, 8'd1, 2'b10, 0, n, lat, sb, tmo);
    vecs++; if (tmo || n != 2 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 || rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0 || rd_last[1] !== 1'b1)
      begin errs++; $display("FAIL wrap_read got resp %h %h data %h %h exp 2 2 0 0", rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]); end
  endtask

  task automatic test_concurrent();
    int t, n, lat, sb; bit w_hs, got_r, got_b, tmo;
    logic [31:0] rv; logic [3:0] ri, bi; logic [1:0] rr, br;
    arid = 4'h5; araddr = 32'h1c000100; arlen = 0; arsize = 2; arburst = 2'b01;
    awid = 4'h6; awaddr = 32'h1c000200; awlen = 0; awsize = 2; awburst = 2'b01;
    t = 0; while (!(arready && awready) && t < 50) begin tick(); t++; end
    arvalid = 1; awvalid = 1; tick();
    vecs++; if (arready !== 1'b0 || awready !== 1'b0) begin errs++; $display("FAIL conc_accept got ar %b aw %b exp 0 0", arready, awready); end
    arvalid = 0; awvalid = 0;
    wdata = 32'h5a5a5a5a; wstrb = 4'hf; wlast = 1; wvalid = 1; rready = 1; bready = 1;
    w_hs = wready; got_r = 0; got_b = 0; rv = '0; ri = '0; rr = '0; bi = '0; br = '0;
    for (int i = 0; i < 30 && !(got_r && got_b); i++) begin
      tick();
      if (w_hs) begin wvalid = 0; wlast = 0; end
      w_hs = wvalid && wready;
      if (rvalid && !got_r) begin got_r = 1; rv = rdata; ri = rid; rr = rresp; end
      if (bvalid && !got_b) begin got_b = 1; bi = bid; br = bresp; end
    end
    tick(); rready = 0; bready = 0; wvalid = 0; wlast = 0;
    vecs++; if (!got_r || rv !== 32'h1 || ri !== 4'h5 || rr !== 2'b00) begin errs++; $display("FAIL conc_read got %0d data %h id %h exp 1/1/5", got_r, rv, ri); end
    vecs++; if (!got_b || br !== 2'b00 || bi !== 4'h6) begin errs++; $display("FAIL conc_write got %0d bresp %h bid %h exp 1/0/6", got_b, br, bi); end
    do_read(4'h2, 32'h1c000200, 8'd0, 2'b01, 0, n, lat, sb, tmo);
    vecs++; if (tmo || rd_data[0] !== 32'h5a5a5a5a) begin errs++; $display("FAIL conc_wr_mem got %h exp 5a5a5a5a", rd_data[0]); end
  endtask

  task automatic test_reset_mid_burst();
    int t, n, lat, sb; bit tmo;
    arid = 4'h7; araddr = 32'h1c000100; arlen = 8'd3; arsize = 2; arburst = 2'b01; arvalid = 1;
    t = 0; while (!arready && t < 50) begin tick(); t++; end
    tick(); arvalid = 0;
    t = 0; while (!rvalid && t < 50) begin tick(); t++; end
    vecs++; if (t >= 50) begin errs++; $display("FAIL mid_rvalid got timeout exp rvalid"); end
    rready = 1; tick();
    vecs++; if (rvalid !== 1'b1 || rdata !== 32'h2) begin errs++; $display("FAIL mid_beat2 got v %b data %h exp 1/2", rvalid, rdata); end
    rready = 0; reset = 1; tick();
    vecs++; if (rvalid !== 1'b0 || arready !== 1'b0) begin errs++; $display("FAIL mid_reset got rvalid %b arready %b exp 0 0", rvalid, arready); end
    reset = 0; tick();
    vecs++; if (arready !== 1'b1) begin errs++; $display("FAIL mid_arready got %b exp 1", arready); end
    do_read(4'hb, 32'h1c000100, 8'd3, 2'b01, 0, n, lat, sb, tmo);
    vecs++; if (tmo || n != 4 || rd_data[0] !== 32'h1 || rd_data[3] !== 32'h4 || rd_last[3] !== 1'b1 || rd_id[3] !== 4'hb)
      begin errs++; $display("FAIL mid_reread got n %0d d0 %h d3 %h exp 4/1/4", n, rd_data[0], rd_data[3]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_incr_burst();
    test_errors();
    test_concurrent();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
